// File: rtl/dmem_responder_if.sv
// Handshake bundle between the CPU memory stage (master) and the data-memory
// responder (slave): a request channel and a response channel.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised RAM behind a valid/ready request and
// response handshake, with programmable wait states, byte-lane stores and an
// error response for misaligned or out-of-range addresses.
module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int CNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] count;

  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic        cap_we;
  logic [3:0]  cap_be;

  logic [31:0] mem [DEPTH];

  logic        enter_resp;
  logic [31:0] eff_addr;
  logic [31:0] eff_wdata;
  logic        eff_we;
  logic [3:0]  eff_be;
  logic        eff_err;
  logic [IDX_W-1:0] word_idx;

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);

  // Pick the request being resolved this edge: the live bus request when a
  // zero-latency build goes straight from IDLE to RESP, else the captured copy.
  always_comb begin
    enter_resp = 1'b0;
    eff_addr   = cap_addr;
    eff_wdata  = cap_wdata;
    eff_we     = cap_we;
    eff_be     = cap_be;
    if (state == IDLE) begin
      eff_addr  = bus.req_addr;
      eff_wdata = bus.req_wdata;
      eff_we    = bus.req_we;
      eff_be    = bus.req_be;
      if (LATENCY == 0) begin
        enter_resp = bus.req_valid;
      end
    end else if (state == WAIT) begin
      enter_resp = (count == CNT_W'(1));
    end
    eff_err  = (eff_addr[1:0] != 2'b00) || (eff_addr[31:2] >= 30'(DEPTH));
    word_idx = eff_addr[IDX_W+1:2];
  end

  // Request/response sequencing plus the registered response payload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      count     <= '0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_we    <= 1'b0;
      cap_be    <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            cap_addr  <= bus.req_addr;
            cap_wdata <= bus.req_wdata;
            cap_we    <= bus.req_we;
            cap_be    <= bus.req_be;
            if (LATENCY == 0) begin
              state <= RESP;
            end else begin
              count <= CNT_W'(LATENCY);
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (enter_resp) begin
        bus.rsp_err   <= eff_err;
        bus.rsp_rdata <= (!eff_we && !eff_err) ? mem[word_idx] : 32'h0;
      end
    end
  end

  // Commit stores lane by lane as the response is formed; reset never clears the array.
  always_ff @(posedge clk) begin
    if (reset && enter_resp && eff_we && !eff_err) begin
      for (int b = 0; b < 4; b++) begin
        if (eff_be[b]) begin
          mem[word_idx][8*b +: 8] <= eff_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one LATENCY=2 and one LATENCY=0 instance sharing
// a single driver, a directed vector table, corner sequences and a random run
// checked against a word-array reference model.
module tb_dmem_responder;

  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  dmem_responder_if if2 ();
  dmem_responder_if if0 ();

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut2 (.clk(clk), .reset(reset), .bus(if2.slave));
  dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));

  logic        sel0 = 1'b0;
  logic        drv_valid = 1'b0;
  logic        drv_we = 1'b0;
  logic [31:0] drv_addr = '0;
  logic [31:0] drv_wdata = '0;
  logic [3:0]  drv_be = '0;
  logic        drv_rsp_ready = 1'b0;

  assign if2.req_valid = drv_valid & ~sel0;
  assign if0.req_valid = drv_valid & sel0;
  assign if2.rsp_ready = drv_rsp_ready & ~sel0;
  assign if0.rsp_ready = drv_rsp_ready & sel0;
  assign if2.req_we = drv_we;
  assign if0.req_we = drv_we;
  assign if2.req_addr = drv_addr;
  assign if0.req_addr = drv_addr;
  assign if2.req_wdata = drv_wdata;
  assign if0.req_wdata = drv_wdata;
  assign if2.req_be = drv_be;
  assign if0.req_be = drv_be;

  logic        cur_req_ready;
  logic        cur_rsp_valid;
  logic [31:0] cur_rdata;
  logic        cur_err;
  assign cur_req_ready = sel0 ? if0.req_ready : if2.req_ready;
  assign cur_rsp_valid = sel0 ? if0.rsp_valid : if2.rsp_valid;
  assign cur_rdata     = sel0 ? if0.rsp_rdata : if2.rsp_rdata;
  assign cur_err       = sel0 ? if0.rsp_err   : if2.rsp_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [2][DEPTH];

  typedef struct {
    logic        sel;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          hold;
    logic        poke;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic model_err(input logic [31:0] addr);
    return (addr % 4 != 0) || (addr / 4 >= DEPTH);
  endfunction

  // One full transaction: present the request, measure latency, optionally
  // stall the response (poking a stray request meanwhile), then handshake.
  task automatic applyStimulus(input string name, input logic sel, input logic we,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, input int hold, input logic poke,
                               input logic [31:0] exp_rdata, input logic exp_err);
    int guard;
    int lat;
    @(negedge clk);
    sel0 = sel;
    drv_we = we;
    drv_addr = addr;
    drv_wdata = wdata;
    drv_be = be;
    drv_valid = 1'b1;
    drv_rsp_ready = 1'b0;
    #1;
    guard = 0;
    while (!cur_req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) checkOutput({name, ".accept_timeout"}, 32'(guard), 32'd0);
    @(posedge clk);
    #1 drv_valid = 1'b0;
    @(negedge clk);
    lat = 0;
    while (!cur_rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({name, ".latency"}, 32'(lat), sel ? 32'd0 : 32'd2);
    checkOutput({name, ".rdata"}, cur_rdata, exp_rdata);
    checkOutput({name, ".err"}, {31'b0, cur_err}, {31'b0, exp_err});
    if (poke) begin
      drv_we = 1'b1;
      drv_addr = 32'h0;
      drv_wdata = 32'hFFFF_FFFF;
      drv_be = 4'hF;
      drv_valid = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput({name, ".hold_valid"}, {31'b0, cur_rsp_valid}, 32'd1);
      checkOutput({name, ".hold_ready"}, {31'b0, cur_req_ready}, 32'd0);
      checkOutput({name, ".hold_rdata"}, cur_rdata, exp_rdata);
      checkOutput({name, ".hold_err"}, {31'b0, cur_err}, {31'b0, exp_err});
    end
    drv_valid = 1'b0;
    drv_rsp_ready = 1'b1;
    @(posedge clk);
    #1 drv_rsp_ready = 1'b0;
    @(negedge clk);
    checkOutput({name, ".post_valid"}, {31'b0, cur_rsp_valid}, 32'd0);
    checkOutput({name, ".post_ready"}, {31'b0, cur_req_ready}, 32'd1);
    checkOutput({name, ".post_rdata"}, cur_rdata, 32'd0);
    checkOutput({name, ".post_err"}, {31'b0, cur_err}, 32'd0);
    if (we && !exp_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) model[sel][addr / 4][8*b +: 8] = wdata[8*b +: 8];
      end
    end
  endtask

  // Predict the response for a request from the reference word array, then run it.
  task automatic modelTxn(input string name, input logic sel, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int hold);
    logic        e;
    logic [31:0] rd;
    e = model_err(addr);
    rd = (!we && !e) ? model[sel][addr / 4] : 32'h0;
    applyStimulus(name, sel, we, addr, wdata, be, hold, 1'b0, rd, e);
  endtask

  initial begin
    vec_t vecs[$];
    logic [31:0] a;
    int r;

    vecs.push_back('{0, 1, 32'h0000_0000, 32'h0BAD_F00D, 4'hF, 0, 0, 32'h0, 0});
    vecs.push_back('{0, 1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 0, 0, 32'h0, 0});
    vecs.push_back('{0, 0, 32'h0000_0008, 32'h0,         4'h0, 0, 0, 32'hDEAD_BEEF, 0});
    vecs.push_back('{0, 1, 32'h0000_000C, 32'h1122_3344, 4'hF, 0, 0, 32'h0, 0});
    vecs.push_back('{0, 1, 32'h0000_000C, 32'hAABB_CCDD, 4'h5, 0, 0, 32'h0, 0});
    vecs.push_back('{0, 0, 32'h0000_000C, 32'h0,         4'h0, 0, 0, 32'h11BB_33DD, 0});
    vecs.push_back('{0, 0, 32'h0000_0006, 32'h0,         4'h0, 0, 0, 32'h0, 1});
    vecs.push_back('{0, 1, 32'h0000_0100, 32'hFFFF_FFFF, 4'hF, 0, 0, 32'h0, 1});
    vecs.push_back('{0, 0, 32'h0000_0000, 32'h0,         4'h0, 0, 0, 32'h0BAD_F00D, 0});
    vecs.push_back('{0, 1, 32'h0000_0008, 32'h0,         4'h0, 0, 0, 32'h0, 0});
    vecs.push_back('{0, 0, 32'h0000_0008, 32'h0,         4'h0, 5, 1, 32'hDEAD_BEEF, 0});
    vecs.push_back('{0, 0, 32'h0000_0000, 32'h0,         4'h0, 0, 0, 32'h0BAD_F00D, 0});
    vecs.push_back('{0, 0, 32'h4000_0008, 32'h0,         4'h0, 0, 0, 32'h0, 1});
    vecs.push_back('{0, 1, 32'h0000_0004, 32'h0000_0007, 4'hF, 0, 0, 32'h0, 0});
    vecs.push_back('{0, 1, 32'h0000_00FC, 32'h1234_5678, 4'hF, 0, 0, 32'h0, 0});
    vecs.push_back('{0, 0, 32'h0000_00FC, 32'h0,         4'h0, 0, 0, 32'h1234_5678, 0});
    vecs.push_back('{1, 1, 32'h0000_0010, 32'hCAFE_F00D, 4'hF, 0, 0, 32'h0, 0});
    vecs.push_back('{1, 0, 32'h0000_0010, 32'h0,         4'h0, 0, 0, 32'hCAFE_F00D, 0});
    vecs.push_back('{1, 1, 32'h0000_0010, 32'h9900_0000, 4'h8, 0, 0, 32'h0, 0});
    vecs.push_back('{1, 0, 32'h0000_0010, 32'h0,         4'h0, 2, 0, 32'h99FE_F00D, 0});
    vecs.push_back('{1, 0, 32'h0000_0013, 32'h0,         4'h0, 0, 0, 32'h0, 1});
    vecs.push_back('{1, 1, 32'h0000_0104, 32'h1,         4'hF, 0, 0, 32'h0, 1});

    // Reset state of both instances while reset is held.
    #12;
    sel0 = 1'b0; #1;
    checkOutput("reset2.req_ready", {31'b0, cur_req_ready}, 32'd1);
    checkOutput("reset2.rsp_valid", {31'b0, cur_rsp_valid}, 32'd0);
    checkOutput("reset2.rdata", cur_rdata, 32'd0);
    checkOutput("reset2.err", {31'b0, cur_err}, 32'd0);
    sel0 = 1'b1; #1;
    checkOutput("reset0.req_ready", {31'b0, cur_req_ready}, 32'd1);
    checkOutput("reset0.rsp_valid", {31'b0, cur_rsp_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Give every word a known value so random loads are predictable.
    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < DEPTH; w++) begin
        modelTxn($sformatf("init%0d_%0d", s, w), s[0], 1'b1, 32'(w * 4), $urandom(), 4'hF, 0);
      end
    end

    $display("[TB] directed vectors");
    foreach (vecs[i]) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].sel, vecs[i].we, vecs[i].addr,
                    vecs[i].wdata, vecs[i].be, vecs[i].hold, vecs[i].poke,
                    vecs[i].exp_rdata, vecs[i].exp_err);
    end

    $display("[TB] reset during wait states");
    @(negedge clk);
    sel0 = 1'b0;
    drv_we = 1'b1;
    drv_addr = 32'h4;
    drv_wdata = 32'h5;
    drv_be = 4'hF;
    drv_valid = 1'b1;
    @(posedge clk);
    #1 drv_valid = 1'b0;
    @(negedge clk);
    checkOutput("midrst.in_wait", {31'b0, cur_req_ready}, 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("midrst.rsp_valid", {31'b0, cur_rsp_valid}, 32'd0);
    checkOutput("midrst.req_ready", {31'b0, cur_req_ready}, 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    applyStimulus("midrst.load", 1'b0, 1'b0, 32'h4, 32'h0, 4'h0, 0, 1'b0, 32'h7, 1'b0);

    $display("[TB] random traffic");
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       a = 32'($urandom_range(0, DEPTH - 1) * 4);
      else if (r == 7) a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
      else if (r == 8) a = $urandom() | 32'h0000_0100;
      else             a = 32'(DEPTH * 4 + $urandom_range(0, 15) * 4);
      modelTxn($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               a, $urandom(), 4'($urandom_range(0, 15)), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
